// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversampled start/data/stop detection with a
// 2-flop input synchronizer, a byte holding register with valid/ack
// handshake, a sticky overrun flag and a one-clock framing error pulse.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     tick_cnt, tick_cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 frame_done_n, frame_err_n;
    logic                 frame_done_p1;
    logic                 rx_sync_p0, rx_s;

    // --- stage p0/p1: bring the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_s       <= rx_sync_p0;
        end
    end

    // Frame FSM register plus counters and one-cycle completion/error strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            frame_done_p1 <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_cnt_n;
            bit_idx       <= bit_idx_n;
            frame_done_p1 <= frame_done_n;
            frame_err     <= frame_err_n;
        end
    end

    // Shift register holds data only, so it carries no reset
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    // Next-state logic: every decision is taken on a sample tick only
    always_comb begin
        state_n      = state;
        tick_cnt_n   = tick_cnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        frame_done_n = 1'b0;
        frame_err_n  = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        tick_cnt_n = '0;
                        state_n    = START;
                    end
                end
                START: begin
                    // Re-check the line half a bit later to reject glitches
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt_n = '0;
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            bit_idx_n = '0;
                            state_n   = DATA;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt_n = '0;
                        shreg_n    = {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_cnt_n = '0;
                        if (rx_s) begin
                            frame_done_n = 1'b1;
                            state_n      = IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = WAIT_IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must not look like a new start bit
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // --- stage p1 -> holding register: load, overrun, and ack handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (frame_done_p1) begin
            if (!rx_valid || rx_ack) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (rx_ack) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames at 64 clk per bit with a
// sample tick every 4 clk and compares against a behavioural model of the
// holding register (valid / data / overrun) plus timing observations.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of what the consumer should see
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovr   = 1'b0;

    // Observation counters maintained by the monitor
    int cyc = 0;
    int tdiv = 0;
    int n_err = 0;
    int n_valid_rise = 0;
    int n_busy = 0;
    int busy_fall_cyc = 0;
    int valid_rise_cyc = 0;
    logic busy_q = 1'b0;
    logic valid_q = 1'b0;

    localparam int BIT_CLK = 64;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk),
        .rst(rst),
        .sample_tick(sample_tick),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ack(rx_ack),
        .overrun(overrun),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on the active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Baud generator stand-in: one-clock tick every 4 clk
    always @(negedge clk) begin
        tdiv = (tdiv + 1) % 4;
        sample_tick = (tdiv == 0);
    end

    // Monitor sampling DUT outputs away from the active edge
    always @(negedge clk) begin
        if (busy_q && !busy) busy_fall_cyc = cyc;
        if (!valid_q && rx_valid) begin
            valid_rise_cyc = cyc;
            n_valid_rise++;
        end
        if (frame_err) n_err++;
        if (busy) n_busy++;
        busy_q = busy;
        valid_q = rx_valid;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_frame(input logic [7:0] b, input logic ack_now);
        if (!m_valid || ack_now) begin
            m_data = b;
            m_valid = 1'b1;
            if (ack_now) m_ovr = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int nstop);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rx = stop_val;
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        model_ack();
    endtask

    task automatic check_model(input string tag);
        n_tests++;
        if (rx_valid !== m_valid) begin n_fail++; $display("FAIL %s rx_valid: got %b expected %b", tag, rx_valid, m_valid); end
        n_tests++;
        if (m_valid && rx_data !== m_data) begin n_fail++; $display("FAIL %s rx_data: got %h expected %h", tag, rx_data, m_data); end
        n_tests++;
        if (overrun !== m_ovr) begin n_fail++; $display("FAIL %s overrun: got %b expected %b", tag, overrun, m_ovr); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rx_data, rx_valid, overrun, frame_err, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h v=%b o=%b fe=%b b=%b expected all 0", rx_data, rx_valid, overrun, frame_err, busy);
        end
    endtask

    task automatic test_basic();
        int e0, s_cyc, lat;
        e0 = n_err;
        s_cyc = cyc;
        send_frame(8'hA5, 1'b1, 2);
        model_frame(8'hA5, 1'b0);
        check_model("basic_a5");
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy); end
        n_tests++;
        if (n_err - e0 != 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses expected 0", n_err - e0); end
        n_tests++;
        if (valid_rise_cyc - busy_fall_cyc != 1) begin n_fail++; $display("FAIL basic_valid_latency: got %0d clk expected 1", valid_rise_cyc - busy_fall_cyc); end
        lat = valid_rise_cyc - s_cyc;
        n_tests++;
        if (lat < 600 || lat > 625) begin n_fail++; $display("FAIL basic_stop_timing: got %0d clk expected 600..625", lat); end
        pulse_ack();
        n_tests++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack: got rx_valid=%b expected 0", rx_valid); end
    endtask

    task automatic test_false_start();
        int e0, b0, v0;
        e0 = n_err; b0 = n_busy; v0 = n_valid_rise;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        n_tests++;
        if (n_busy - b0 == 0) begin n_fail++; $display("FAIL false_start_seen: got busy cycles 0 expected >0"); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy: got %b expected 0", busy); end
        n_tests++;
        if (n_err - e0 != 0 || n_valid_rise - v0 != 0) begin
            n_fail++; $display("FAIL false_start_flags: got err=%0d valid_rises=%0d expected 0/0", n_err - e0, n_valid_rise - v0);
        end
        check_model("false_start");
        send_frame(8'h5A, 1'b1, 2);
        model_frame(8'h5A, 1'b0);
        check_model("after_false_5a");
        pulse_ack();
    endtask

    task automatic test_frame_err();
        int e0, v0;
        e0 = n_err; v0 = n_valid_rise;
        send_frame(8'h3C, 1'b0, 4);
        n_tests++;
        if (n_err - e0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", n_err - e0); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait_idle_busy: got %b expected 1", busy); end
        check_model("ferr_no_byte");
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_busy: got %b expected 0", busy); end
        n_tests++;
        if (n_err - e0 != 1 || n_valid_rise - v0 != 0) begin
            n_fail++; $display("FAIL ferr_spurious: got err=%0d valid_rises=%0d expected 1/0", n_err - e0, n_valid_rise - v0);
        end
        send_frame(8'h01, 1'b1, 2);
        model_frame(8'h01, 1'b0);
        check_model("ferr_next_01");
        pulse_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 2);
        model_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b1, 2);
        model_frame(8'h22, 1'b0);
        check_model("overrun_set");
        pulse_ack();
        check_model("overrun_cleared");
    endtask

    task automatic test_ack_coincide();
        int i;
        send_frame(8'h11, 1'b1, 2);
        model_frame(8'h11, 1'b0);
        fork
            send_frame(8'h22, 1'b1, 2);
            begin
                for (i = 0; i < 200 && !busy; i++) @(negedge clk);
                for (i = 0; i < 1000 && busy; i++) @(negedge clk);
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL coincide_timeout: got busy=%b expected 0", busy);
                end
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        model_frame(8'h22, 1'b1);
        check_model("coincide_22");
        pulse_ack();
    endtask

    task automatic test_reset_mid_frame();
        int e0, v0;
        send_frame(8'h6B, 1'b1, 2);
        model_frame(8'h6B, 1'b0);
        send_frame(8'h77, 1'b1, 2);
        model_frame(8'h77, 1'b0);
        check_model("pre_reset");
        e0 = n_err; v0 = n_valid_rise;
        fork
            send_frame(8'hFF, 1'b1, 2);
            begin
                repeat (3 * BIT_CLK + 20) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                n_tests++;
                if ({rx_data, rx_valid, overrun, frame_err, busy} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL mid_reset_state: got data=%h v=%b o=%b fe=%b b=%b expected all 0", rx_data, rx_valid, overrun, frame_err, busy);
                end
            end
        join
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
        n_tests++;
        if (n_err - e0 != 0 || n_valid_rise - v0 != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_abandon: got err=%0d valid_rises=%0d busy=%b expected 0/0/0", n_err - e0, n_valid_rise - v0, busy);
        end
        send_frame(8'h80, 1'b1, 2);
        model_frame(8'h80, 1'b0);
        check_model("after_reset_80");
        pulse_ack();
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 100)) @(negedge clk);
            send_frame(b, 1'b1, 2);
            model_frame(b, 1'b0);
            check_model($sformatf("random_%0d", k));
            if ($urandom_range(0, 1) == 1) pulse_ack();
        end
        if (m_valid) pulse_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        logic [7:0] got[$];
        int i;
        logic timed_out;
        timed_out = 1'b0;
        for (int k = 0; k < 10; k++) sent.push_back(8'($urandom));
        repeat ($urandom_range(1, 40)) @(negedge clk);
        fork
            for (int k = 0; k < 10; k++) send_frame(sent[k], 1'b1, 2);
            for (int k = 0; k < 10; k++) begin
                if (!timed_out) begin
                    for (i = 0; i < 2000 && !rx_valid; i++) @(negedge clk);
                    if (!rx_valid) begin
                        timed_out = 1'b1;
                    end else begin
                        got.push_back(rx_data);
                        rx_ack = 1'b1;
                        @(negedge clk);
                        rx_ack = 1'b0;
                    end
                end
            end
        join
        n_tests++;
        if (got.size() != 10) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected 10", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            n_tests++;
            if (got[k] !== sent[k]) begin n_fail++; $display("FAIL b2b_byte_%0d: got %h expected %h", k, got[k], sent[k]); end
        end
        n_tests++;
        if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end_flags: got overrun=%b rx_valid=%b expected 0/0", overrun, rx_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_ack_coincide();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
